// File: rtl/updown_mode_counter.sv
// Up/down counter with programmable modulus and wrap/saturate/one-shot/ping-pong modes.
// Optional registered Gray-code output when UPDOWN_MODE_COUNTER_GRAY_EN is defined.
module updown_mode_counter #(
    parameter int WIDTH       = 4,
    parameter int MAX_VALUE   = 2**WIDTH-1,
    parameter int RESET_VALUE = MAX_VALUE
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_term,
    output logic             wrap,
    output logic             done
`ifdef UPDOWN_MODE_COUNTER_GRAY_EN
   ,output logic [WIDTH-1:0] gray_count
`endif
);

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;
    localparam logic [1:0] MODE_PP   = 2'b11;

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    if (WIDTH < 2 || MAX_VALUE < 1 || MAX_VALUE > 2**WIDTH-1 ||
        RESET_VALUE < 0 || RESET_VALUE > MAX_VALUE) begin : g_bad_param
        $error("updown_mode_counter: illegal WIDTH/MAX_VALUE/RESET_VALUE");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_done;
    logic             r_pp_dir;

    logic             w_eff_up;
    logic [WIDTH-1:0] w_term;
    logic             w_at_term;
    logic [WIDTH-1:0] w_load_clamp;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_done_nxt;
    logic             w_pp_nxt;

    assign w_eff_up     = (mode == MODE_PP) ? r_pp_dir : dir;
    assign w_term       = w_eff_up ? MAXV : '0;
    assign w_at_term    = (r_count == w_term);
    assign w_load_clamp = (load_value > MAXV) ? MAXV : load_value;
    assign w_step       = w_eff_up ? (r_count + ONE) : (r_count - ONE);

    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = r_done;
        w_pp_nxt    = r_pp_dir;
        if (load) begin
            w_count_nxt = w_load_clamp;
            w_done_nxt  = 1'b0;
            w_pp_nxt    = dir;
        end else if (en) begin
            if (mode == MODE_ONE && r_done) begin
                w_count_nxt = r_count;
            end else if (!w_at_term) begin
                w_count_nxt = w_step;
            end else begin
                unique case (mode)
                    MODE_WRAP: begin
                        w_count_nxt = w_eff_up ? '0 : MAXV;
                        w_wrap_nxt  = 1'b1;
                    end
                    MODE_SAT: begin
                        w_count_nxt = r_count;
                    end
                    MODE_ONE: begin
                        w_done_nxt = 1'b1;
                    end
                    MODE_PP: begin
                        // Turn around and take one step back the other way.
                        w_pp_nxt    = ~r_pp_dir;
                        w_count_nxt = r_pp_dir ? (MAXV - ONE) : ONE;
                        w_wrap_nxt  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_count  <= RSTV;
            r_wrap   <= 1'b0;
            r_done   <= 1'b0;
            r_pp_dir <= 1'b1;
        end else begin
            r_count  <= w_count_nxt;
            r_wrap   <= w_wrap_nxt;
            r_done   <= w_done_nxt;
            r_pp_dir <= w_pp_nxt;
        end
    end

`ifdef UPDOWN_MODE_COUNTER_GRAY_EN
    logic [WIDTH-1:0] r_gray;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_gray <= RSTV ^ (RSTV >> 1);
        end else begin
            r_gray <= w_count_nxt ^ (w_count_nxt >> 1);
        end
    end

    assign gray_count = r_gray;
`endif

    assign count   = r_count;
    assign at_term = w_at_term;
    assign wrap    = r_wrap;
    assign done    = r_done;

endmodule

// File: tb/tb_updown_mode_counter.sv
// Directed bench for updown_mode_counter across several modulus settings.
// Shared stimulus drives four instances; each phase reloads the instance it checks.
module tb_updown_mode_counter;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] a_count, b_count, c_count, d_count;
    logic       a_term, b_term, c_term, d_term;
    logic       a_wrap, b_wrap, c_wrap, d_wrap;
    logic       a_done, b_done, c_done, d_done;
`ifdef UPDOWN_MODE_COUNTER_GRAY_EN
    logic [3:0] a_gray, b_gray, c_gray, d_gray;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    updown_mode_counter u_a (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_value(load_value), .count(a_count),
        .at_term(a_term), .wrap(a_wrap), .done(a_done)
`ifdef UPDOWN_MODE_COUNTER_GRAY_EN
       ,.gray_count(a_gray)
`endif
    );

    updown_mode_counter #(.MAX_VALUE(9)) u_b (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_value(load_value), .count(b_count),
        .at_term(b_term), .wrap(b_wrap), .done(b_done)
`ifdef UPDOWN_MODE_COUNTER_GRAY_EN
       ,.gray_count(b_gray)
`endif
    );

    updown_mode_counter #(.MAX_VALUE(3)) u_c (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_value(load_value), .count(c_count),
        .at_term(c_term), .wrap(c_wrap), .done(c_done)
`ifdef UPDOWN_MODE_COUNTER_GRAY_EN
       ,.gray_count(c_gray)
`endif
    );

    updown_mode_counter #(.MAX_VALUE(1)) u_d (
        .clk(clk), .clear(clear), .en(en), .dir(dir), .mode(mode),
        .load(load), .load_value(load_value), .count(d_count),
        .at_term(d_term), .wrap(d_wrap), .done(d_done)
`ifdef UPDOWN_MODE_COUNTER_GRAY_EN
       ,.gray_count(d_gray)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int c_cnt[7]  = '{1, 2, 3, 2, 1, 0, 1};
    int c_wr[7]   = '{0, 0, 0, 1, 0, 0, 1};
    int d_cnt[7]  = '{1, 0, 1, 0, 1, 0, 1};
    int d_wr[7]   = '{0, 1, 1, 1, 1, 1, 1};

    initial begin
        #1 clear = 1'b1;
        #1;
        check("rst_a_count", a_count, 15);
        check("rst_a_wrap", a_wrap, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_term", a_term, 0);
        check("rst_b_count", b_count, 9);
        check("rst_c_count", c_count, 3);
`ifdef UPDOWN_MODE_COUNTER_GRAY_EN
        check("rst_a_gray", a_gray, 8);
`endif
        #1 clear = 1'b0;
        en = 1'b1;

        for (int i = 1; i <= 8; i++) begin
            step();
            check("down_a", a_count, 15 - i);
        end
        #2 clear = 1'b1;
        #1;
        check("async_clr_count", a_count, 15);
        check("async_clr_wrap", a_wrap, 0);
        check("async_clr_done", a_done, 0);
        clear = 1'b0;
        step();
        check("post_clr_a", a_count, 14);
        step();
        check("post_clr_a", a_count, 13);

        mode = 2'b00; dir = 1'b1; load = 1'b1; load_value = 4'd0;
        step();
        load = 1'b0;
        check("wrap_up_load", b_count, 0);
        check("wrap_up_load_w", b_wrap, 0);
        for (int i = 1; i <= 11; i++) begin
            int e;
            step();
            e = i % 10;
            check("wrap_up_cnt", b_count, e);
            check("wrap_up_wrap", b_wrap, (e == 0) ? 1 : 0);
            check("wrap_up_term", b_term, (e == 9) ? 1 : 0);
        end

        dir = 1'b0; load = 1'b1; load_value = 4'd0;
        step();
        load = 1'b0;
        check("wrap_dn_load", b_count, 0);
        check("wrap_dn_term", b_term, 1);
        step();
        check("wrap_dn_cnt", b_count, 9);
        check("wrap_dn_wrap", b_wrap, 1);
        step();
        check("wrap_dn_cnt2", b_count, 8);
        check("wrap_dn_wrap2", b_wrap, 0);

        mode = 2'b01; dir = 1'b1; load = 1'b1; load_value = 4'd8;
        step();
        load = 1'b0;
        check("sat_load", b_count, 8);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat_cnt", b_count, 9);
            check("sat_wrap", b_wrap, 0);
        end

        mode = 2'b10; dir = 1'b0; load = 1'b1; load_value = 4'd2;
        step();
        load = 1'b0;
        check("one_load", b_count, 2);
        check("one_load_done", b_done, 0);
        step();
        check("one_cnt1", b_count, 1);
        check("one_done1", b_done, 0);
        step();
        check("one_cnt0", b_count, 0);
        check("one_done0", b_done, 0);
        step();
        check("one_hold", b_count, 0);
        check("one_done", b_done, 1);
        check("one_wrap", b_wrap, 0);
        dir = 1'b1;
        step();
        check("one_dir_cnt", b_count, 0);
        check("one_dir_done", b_done, 1);
        dir = 1'b0;
        step();
        check("one_dir0_cnt", b_count, 0);
        check("one_dir0_done", b_done, 1);
        load = 1'b1; load_value = 4'd5;
        step();
        load = 1'b0;
        check("one_reload", b_count, 5);
        check("one_reload_d", b_done, 0);
        step();
        check("one_resume", b_count, 4);

        mode = 2'b11; dir = 1'b1; load = 1'b1; load_value = 4'd0;
        step();
        load = 1'b0;
        check("pp_load_c", c_count, 0);
        check("pp_load_d", d_count, 0);
        for (int i = 0; i < 7; i++) begin
            step();
            check("pp_c_cnt", c_count, c_cnt[i]);
            check("pp_c_wrap", c_wrap, c_wr[i]);
            check("pp_d_cnt", d_count, d_cnt[i]);
            check("pp_d_wrap", d_wrap, d_wr[i]);
            if (i == 2) check("pp_c_term", c_term, 1);
        end

        mode = 2'b01; dir = 1'b1; load = 1'b1; en = 1'b1;
        load_value = 4'd12;
        step();
        check("clamp_b", b_count, 9);
        check("clamp_b_wrap", b_wrap, 0);
        check("noclamp_a", a_count, 12);
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_cnt", b_count, 9);
            check("hold_wrap", b_wrap, 0);
        end
        mode = 2'b00; dir = 1'b1;
        #1 check("term_up", b_term, 1);
        dir = 1'b0;
        #1 check("term_dn", b_term, 0);

`ifdef UPDOWN_MODE_COUNTER_GRAY_EN
        begin
            logic [3:0] prev_g;
            mode = 2'b00; dir = 1'b1; load = 1'b1; load_value = 4'd0;
            en = 1'b1;
            step();
            load = 1'b0;
            check("gray_load", a_gray, 0);
            prev_g = a_gray;
            for (int i = 1; i <= 16; i++) begin
                logic [3:0] e;
                step();
                e = 4'(i % 16);
                check("gray_cnt", a_count, e);
                check("gray_val", a_gray, e ^ (e >> 1));
                check("gray_1bit", $countones(a_gray ^ prev_g), 1);
                prev_g = a_gray;
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
